// File: rtl/prince_sbox_ctrl_pkg.sv
// Shared types and sizes for the serial masked PRINCE S-box layer controller.
package prince_sbox_ctrl_pkg;

    localparam int unsigned NIBBLES  = 16;
    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned STATE_W  = NIBBLES * NIBBLE_W;
    localparam int unsigned RAND_W   = 18;
    localparam int unsigned CNT_W    = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_DRAIN,
        ST_HOLD
    } state_e;

endpackage

// File: rtl/prince_share_shift_reg.sv
// One share of the state: parallel load, nibble shift-in at the LSB end, and
// synchronous clear. Clear has priority over load, load over shift.
module prince_share_shift_reg
    import prince_sbox_ctrl_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  logic                load_i,
    input  logic [STATE_W-1:0]  load_val_i,
    input  logic                shift_i,
    input  logic [NIBBLE_W-1:0] shift_nib_i,
    output logic [STATE_W-1:0]  q_o
);

    logic [STATE_W-1:0] q_q;
    logic [STATE_W-1:0] q_d;

    // Next value: clear, load, or shift the new nibble in from the bottom.
    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (load_i) begin
            q_d = load_val_i;
        end else if (shift_i) begin
            q_d = {q_q[STATE_W-NIBBLE_W-1:0], shift_nib_i};
        end
    end

    // Share storage register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/prince_sbox_layer_ctrl.sv
// Serial scheduler feeding a 2-share 64-bit PRINCE state through one shared
// masked S-box, MSB nibble first, one nibble per fresh PRNG word.
// Optional build macro: PRINCE_SBOX_CTRL_ZEROIZE_EN clears the result and
// input registers on the output handshake and blanks the S-box inputs in IDLE.
module prince_sbox_layer_ctrl
    import prince_sbox_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [STATE_W-1:0]  state_in_share1,
    input  logic [STATE_W-1:0]  state_in_share2,
    output logic                busy,
    input  logic [RAND_W-1:0]   rand_in,
    input  logic                rand_valid,
    output logic                rand_req,
    output logic [NIBBLE_W-1:0] sbox_in_share1,
    output logic [NIBBLE_W-1:0] sbox_in_share2,
    output logic [RAND_W-1:0]   sbox_rand,
    input  logic [NIBBLE_W-1:0] sbox_out_share1,
    input  logic [NIBBLE_W-1:0] sbox_out_share2,
    output logic [STATE_W-1:0]  state_out_share1,
    output logic [STATE_W-1:0]  state_out_share2,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                fed_d_q;
    logic                busy_q;
    logic                out_valid_q;

    logic                feed;
    logic                capture;
    logic                handshake;
    logic                load_in;
    logic                clr_regs;
    logic [STATE_W-1:0]  in1_q;
    logic [STATE_W-1:0]  in2_q;
    logic [NIBBLE_W-1:0] nib1;
    logic [NIBBLE_W-1:0] nib2;

    assign feed      = (state_q == ST_FEED) && rand_valid;
    assign capture   = fed_d_q && ((state_q == ST_FEED) || (state_q == ST_DRAIN));
    assign handshake = (state_q == ST_HOLD) && out_valid_q && out_ready;
    assign load_in   = (state_q == ST_IDLE) && start;

`ifdef PRINCE_SBOX_CTRL_ZEROIZE_EN
    assign clr_regs = handshake;
`else
    assign clr_regs = 1'b0;
`endif

    // Sequencer: IDLE -> FEED (one nibble per valid PRNG word) -> DRAIN -> HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            fed_d_q     <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            fed_d_q <= feed;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_FEED;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_FEED: begin
                    if (feed) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_NIB) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    state_q     <= ST_HOLD;
                    out_valid_q <= 1'b1;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Select nibble cnt_q of each input share, counting from the MSB end.
    always_comb begin
        nib1 = '0;
        nib2 = '0;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                nib1 = in1_q[STATE_W-1-NIBBLE_W*i -: NIBBLE_W];
                nib2 = in2_q[STATE_W-1-NIBBLE_W*i -: NIBBLE_W];
            end
        end
    end

    // S-box inputs: blanked on PRNG stalls so the dummy evaluation carries no data.
    always_comb begin
        sbox_in_share1 = nib1;
        sbox_in_share2 = nib2;
        if ((state_q == ST_FEED) && !feed) begin
            sbox_in_share1 = '0;
            sbox_in_share2 = '0;
        end
`ifdef PRINCE_SBOX_CTRL_ZEROIZE_EN
        if (state_q == ST_IDLE) begin
            sbox_in_share1 = '0;
            sbox_in_share2 = '0;
        end
`endif
    end

    assign sbox_rand = feed ? rand_in : '0;
    assign rand_req  = feed;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;

    // Input shares are indexed in place; the result shares shift in at the
    // bottom, so after NIBBLES captures the first result sits in the MSB nibble.
    prince_share_shift_reg u_in_share1 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clr_i       (clr_regs),
        .load_i      (load_in),
        .load_val_i  (state_in_share1),
        .shift_i     (1'b0),
        .shift_nib_i ('0),
        .q_o         (in1_q)
    );

    prince_share_shift_reg u_in_share2 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clr_i       (clr_regs),
        .load_i      (load_in),
        .load_val_i  (state_in_share2),
        .shift_i     (1'b0),
        .shift_nib_i ('0),
        .q_o         (in2_q)
    );

    prince_share_shift_reg u_out_share1 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clr_i       (clr_regs),
        .load_i      (1'b0),
        .load_val_i  ('0),
        .shift_i     (capture),
        .shift_nib_i (sbox_out_share1),
        .q_o         (state_out_share1)
    );

    prince_share_shift_reg u_out_share2 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clr_i       (clr_regs),
        .load_i      (1'b0),
        .load_val_i  ('0),
        .shift_i     (capture),
        .shift_nib_i (sbox_out_share2),
        .q_o         (state_out_share2)
    );

endmodule

// File: tb/tb_prince_sbox_layer_ctrl.sv
// Bench for prince_sbox_layer_ctrl: a masked PRINCE S-box stand-in with one
// register stage, a nibble-level result model, and a per-cycle comparator.
module tb_prince_sbox_layer_ctrl;
    import prince_sbox_ctrl_pkg::*;

    localparam logic [63:0] PT2   = 64'h0123456789ABCDEF;
    localparam logic [63:0] MASK2 = 64'hA5A5A5A5A5A5A5A5;
    localparam logic [63:0] CT2   = 64'hBF32AC916780E5D4;
    localparam logic [63:0] CT0   = 64'hBBBBBBBBBBBBBBBB;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] state_in_share1;
    logic [63:0] state_in_share2;
    logic        busy;
    logic [17:0] rand_in;
    logic        rand_valid;
    logic        rand_req;
    logic [3:0]  sbox_in_share1;
    logic [3:0]  sbox_in_share2;
    logic [17:0] sbox_rand;
    logic [3:0]  sbox_out_share1;
    logic [3:0]  sbox_out_share2;
    logic [63:0] state_out_share1;
    logic [63:0] state_out_share2;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    prince_sbox_layer_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .state_in_share1  (state_in_share1),
        .state_in_share2  (state_in_share2),
        .busy             (busy),
        .rand_in          (rand_in),
        .rand_valid       (rand_valid),
        .rand_req         (rand_req),
        .sbox_in_share1   (sbox_in_share1),
        .sbox_in_share2   (sbox_in_share2),
        .sbox_rand        (sbox_rand),
        .sbox_out_share1  (sbox_out_share1),
        .sbox_out_share2  (sbox_out_share2),
        .state_out_share1 (state_out_share1),
        .state_out_share2 (state_out_share2),
        .out_valid        (out_valid),
        .out_ready        (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] prince_s(input logic [3:0] x);
        case (x)
            4'h0: return 4'hB;  4'h1: return 4'hF;  4'h2: return 4'h3;  4'h3: return 4'h2;
            4'h4: return 4'hA;  4'h5: return 4'hC;  4'h6: return 4'h9;  4'h7: return 4'h1;
            4'h8: return 4'h6;  4'h9: return 4'h7;  4'hA: return 4'h8;  4'hB: return 4'h0;
            4'hC: return 4'hE;  4'hD: return 4'h5;  4'hE: return 4'hD;  default: return 4'h4;
        endcase
    endfunction

    function automatic logic [3:0] mask_of(input logic [17:0] r);
        return r[3:0] ^ r[17:14];
    endfunction

    function automatic logic [3:0] nib(input logic [63:0] v, input int idx);
        return v[63-4*idx -: 4];
    endfunction

    // Masked S-box stand-in: one register stage, output mask drawn from the randomness.
    logic [3:0] sb_s;
    logic [3:0] sb_m;
    always @(posedge clk) begin
        sb_s <= prince_s(sbox_in_share1 ^ sbox_in_share2);
        sb_m <= mask_of(sbox_rand);
    end
    assign sbox_out_share1 = sb_s ^ sb_m;
    assign sbox_out_share2 = sb_m;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model state for the current operation.
    logic [63:0] m_in1, m_in2, m_exp1, m_exp2;
    logic [17:0] rnd [16];
    int          stall [16];
    logic        feeding = 1'b0;
    logic        chk_en  = 1'b0;
    int          op_seq  = 0;

    // Comparator-owned counters.
    int seen_seq = 0;
    int exp_idx  = 0;
    int pulses   = 0;

    // Per-cycle comparator, sampling on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            if (op_seq != seen_seq) begin
                seen_seq = op_seq;
                exp_idx  = 0;
                pulses   = 0;
            end
            if (rand_req) pulses++;
            check("rand_req", rand_req, feeding && rand_valid);
            if (feeding && rand_valid) begin
                if (exp_idx < 16) begin
                    check("sbox_in_share1", sbox_in_share1, nib(m_in1, exp_idx));
                    check("sbox_in_share2", sbox_in_share2, nib(m_in2, exp_idx));
                    check("sbox_rand", sbox_rand, rand_in);
                end
                exp_idx++;
            end else if (feeding) begin
                check("stall_sbox_in_share1", sbox_in_share1, 4'h0);
                check("stall_sbox_in_share2", sbox_in_share2, 4'h0);
                check("stall_sbox_rand", sbox_rand, 18'h0);
            end
            if (feeding) check("out_valid_during_feed", out_valid, 1'b0);
            if (out_valid) begin
                check("state_out_share1", state_out_share1, m_exp1);
                check("state_out_share2", state_out_share2, m_exp2);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_rand_req"}, rand_req, 1'b0);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_sbox_in_share1"}, sbox_in_share1, 4'h0);
        check({tag, "_sbox_in_share2"}, sbox_in_share2, 4'h0);
        check({tag, "_sbox_rand"}, sbox_rand, 18'h0);
        check({tag, "_state_out_share1"}, state_out_share1, 64'h0);
        check({tag, "_state_out_share2"}, state_out_share2, 64'h0);
    endtask

    logic [63:0] got1, got2;

    // One full operation: start, feed with the stall table, wait for the result, hand it off.
    task automatic run_op(input logic [63:0] s1, input logic [63:0] s2,
                          input int hold, input int abort_at, input bit poke);
        int cyc;
        int total_stall;
        int waited;
        logic [3:0] m;
        total_stall = 0;
        m_in1 = s1;
        m_in2 = s2;
        for (int i = 0; i < 16; i++) begin
            rnd[i] = 18'($urandom);
            m = mask_of(rnd[i]);
            m_exp2[63-4*i -: 4] = m;
            m_exp1[63-4*i -: 4] = prince_s(nib(s1, i) ^ nib(s2, i)) ^ m;
            total_stall += stall[i];
        end
        op_seq++;
        got1 = '0;
        got2 = '0;
        state_in_share1 = s1;
        state_in_share2 = s2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        feeding = 1'b1;
        cyc = 1;
        for (int k = 0; k < 16; k++) begin
            repeat (stall[k]) begin
                rand_valid = 1'b0;
                rand_in = 18'($urandom) | 18'h1;
                @(posedge clk); #1;
                cyc++;
            end
            if (k == abort_at) begin
                feeding = 1'b0;
                rand_valid = 1'b1;
                rand_in = 18'h3FFFF;
                rst_n = 1'b0;
                #1;
                check_all_zero("abort");
                @(posedge clk); #1;
                rand_valid = 1'b0;
                rst_n = 1'b1;
                @(posedge clk); #1;
                return;
            end
            rand_valid = 1'b1;
            rand_in = rnd[k];
            if (poke && (k % 4 == 2)) begin
                start = 1'b1;
                state_in_share1 = 64'($urandom);
                state_in_share2 = 64'($urandom);
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        feeding = 1'b0;
        rand_valid = 1'b1;
        rand_in = 18'($urandom);
        out_ready = (hold == 0);
        waited = 0;
        while (!out_valid && waited < 40) begin
            @(posedge clk); #1;
            cyc++;
            waited++;
        end
        check("out_valid_cycle", cyc, 18 + total_stall);
        check("rand_req_pulses", pulses, 16);
        got1 = state_out_share1;
        got2 = state_out_share2;
        for (int h = 0; h < hold; h++) begin
            start = poke;
            @(posedge clk); #1;
            check("hold_out_valid", out_valid, 1'b1);
            check("hold_busy", busy, 1'b1);
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        rand_valid = 1'b0;
        check("post_hs_out_valid", out_valid, 1'b0);
        check("post_hs_busy", busy, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        state_in_share1 = '0;
        state_in_share2 = '0;
        rand_valid = 1'b0;
        rand_in = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) stall[i] = 0;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        check("idle_busy", busy, 1'b0);

        // All-zero state.
        run_op(64'h0, 64'h0, 0, -1, 1'b0);
        check("zero_state_result", got1 ^ got2, CT0);

        // Plaintext split into two shares.
        run_op(PT2 ^ MASK2, MASK2, 0, -1, 1'b0);
        check("pt2_result", got1 ^ got2, CT2);
        check("share1_not_plain", got1 != PT2, 1'b1);
        check("share2_not_plain", got2 != PT2, 1'b1);

        @(posedge clk); #1;
`ifdef PRINCE_SBOX_CTRL_ZEROIZE_EN
        check("zeroize_state_out_share1", state_out_share1, 64'h0);
        check("zeroize_state_out_share2", state_out_share2, 64'h0);
        check("zeroize_sbox_in_share1", sbox_in_share1, 4'h0);
        check("zeroize_sbox_in_share2", sbox_in_share2, 4'h0);
`else
        check("retain_state_out_share1", state_out_share1, m_exp1);
        check("retain_state_out_share2", state_out_share2, m_exp2);
`endif

        // PRNG stalls at nibble 5 (3 cycles) and nibble 15 (1 cycle).
        stall[5] = 3;
        stall[15] = 1;
        run_op(PT2 ^ MASK2, MASK2, 0, -1, 1'b0);
        check("stall_result", got1 ^ got2, CT2);
        stall[5] = 0;
        stall[15] = 0;

        // Backpressure in HOLD plus ignored start pulses while busy.
        run_op(PT2 ^ MASK2, MASK2, 10, -1, 1'b1);
        check("backpressure_result", got1 ^ got2, CT2);
        @(posedge clk); #1;
        check("no_queued_start", busy, 1'b0);

        // Reset during FEED at cnt=7, then a clean operation.
        run_op(PT2 ^ MASK2, MASK2, 0, 7, 1'b0);
        check("after_abort_busy", busy, 1'b0);
        run_op(PT2 ^ MASK2, MASK2, 0, -1, 1'b0);
        check("after_abort_result", got1 ^ got2, CT2);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
